// File: rtl/dma_burst_copier.sv
// rtl/dma_burst_copier.sv - AXI4 initiator copying a byte block burst by burst through a local buffer
module dma_burst_copier #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MAX_BEATS  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   src_addr,
    input  logic [ADDR_WIDTH-1:0]   dst_addr,
    input  logic [15:0]             byte_len,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic [ID_WIDTH-1:0]     awid,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [1:0]              bresp,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic [ID_WIDTH-1:0]     arid,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast
);
    localparam int BPB    = DATA_WIDTH / 8;
    localparam int BSHIFT = $clog2(BPB);
    localparam int IDX_W  = $clog2(MAX_BEATS);
    localparam int BEAT_W = $clog2(MAX_BEATS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] src, dst;
    logic [15:0]           rem;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] buf_mem [MAX_BEATS];

    logic [16:0]           rem_beats, src_room, dst_room, beats_min;
    logic [BEAT_W-1:0]     beats;
    logic [15:0]           burst_bytes, rem_after;
    logic                  last_w;

    // src/dst/rem only move on the B handshake, so the burst size derived
    // from them stays constant for the whole AR..B sequence.
    always_comb begin
        rem_beats = 17'(rem >> BSHIFT);
        src_room  = 17'((13'd4096 - {1'b0, src[11:0]}) >> BSHIFT);
        dst_room  = 17'((13'd4096 - {1'b0, dst[11:0]}) >> BSHIFT);
        beats_min = 17'(MAX_BEATS);
        if (rem_beats < beats_min) beats_min = rem_beats;
        if (src_room < beats_min)  beats_min = src_room;
        if (dst_room < beats_min)  beats_min = dst_room;
        beats       = BEAT_W'(beats_min);
        burst_bytes = 16'(beats) << BSHIFT;
        rem_after   = rem - burst_bytes;
        last_w      = (BEAT_W'(idx) == beats - BEAT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start)           state_nxt = (byte_len == 16'd0) ? S_DONE : S_AR;
            S_AR:   if (arready)         state_nxt = S_R;
            S_R:    if (rvalid && rlast) state_nxt = S_AW;
            S_AW:   if (awready)         state_nxt = S_W;
            S_W:    if (wready && last_w) state_nxt = S_B;
            S_B:    if (bvalid)          state_nxt = (rem_after == 16'd0) ? S_DONE : S_AR;
            S_DONE:                      state_nxt = S_IDLE;
            default:                     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src <= '0;
            dst <= '0;
            rem <= '0;
            idx <= '0;
            err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    src <= src_addr;
                    dst <= dst_addr;
                    rem <= byte_len;
                    idx <= '0;
                    err <= 1'b0;
                end
                S_R: if (rvalid) begin
                    idx <= rlast ? '0 : idx + 1'b1;
                    if (rresp != 2'b00) err <= 1'b1;
                end
                S_W: if (wready) idx <= last_w ? '0 : idx + 1'b1;
                S_B: if (bvalid) begin
                    src <= src + ADDR_WIDTH'(burst_bytes);
                    dst <= dst + ADDR_WIDTH'(burst_bytes);
                    rem <= rem_after;
                    if (bresp != 2'b00) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_R && rvalid) buf_mem[idx] <= rdata;
    end

    always_comb begin
        arvalid = (state == S_AR);
        rready  = (state == S_R);
        awvalid = (state == S_AW);
        wvalid  = (state == S_W);
        wlast   = (state == S_W) && last_w;
        bready  = (state == S_B);
        done    = (state == S_DONE);
        busy    = (state != S_IDLE) && (state != S_DONE);
        araddr  = src;
        awaddr  = dst;
        arlen   = 8'(beats - BEAT_W'(1));
        awlen   = 8'(beats - BEAT_W'(1));
        arsize  = 3'(BSHIFT);
        awsize  = 3'(BSHIFT);
        arburst = 2'b01;
        awburst = 2'b01;
        arid    = '0;
        awid    = '0;
        wdata   = buf_mem[idx];
        wstrb   = '1;
    end
endmodule

// File: tb/tb_dma_burst_copier.sv
// tb/tb_dma_burst_copier.sv - randomized bench: AXI memory responder, copy model, per-cycle channel checks
module tb_dma_burst_copier;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] byte_len = '0;
    logic        busy, done, err;
    logic        awvalid, wvalid, wlast, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0, rlast = 1'b0;
    logic [31:0] awaddr, araddr, wdata;
    logic [31:0] rdata = '0;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst;
    logic [3:0]  awid, arid, wstrb;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;

    dma_burst_copier dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .byte_len(byte_len), .busy(busy), .done(done), .err(err),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awid(awid), .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .wstrb(wstrb), .wlast(wlast), .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arid(arid), .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .rresp(rresp), .rlast(rlast)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;
    logic [31:0] mem [0:4095];

    logic [31:0] exp_ar_addr[$], exp_aw_addr[$], exp_wdata[$];
    int          exp_ar_len[$], exp_aw_len[$];

    int dly = 0, r_lat = 0, bresp_err_burst = -1, rresp_err_beat = -1;
    int r_count = 0, b_count = 0;

    // responder bookkeeping and last-negedge snapshots of DUT outputs
    logic        s_rst = 1'b0, s_ar = 1'b0, s_aw = 1'b0, s_w = 1'b0, s_rr = 1'b0, s_br = 1'b0, s_wlast = 1'b0;
    logic [31:0] s_araddr = '0, s_awaddr = '0, s_wdata = '0;
    logic [7:0]  s_arlen = '0, s_awlen = '0;
    logic [8:0]  s_arattr = '0, s_awattr = '0;
    logic [3:0]  s_wstrb = '0;
    logic [31:0] rd_addr[$], wr_addr[$];
    int          rd_len[$], wr_len[$];
    int          r_beat = 0, w_beat = 0, r_wait = 0, ar_cnt = 0, aw_cnt = 0, w_cnt = 0, b_pend = 0;
    bit          hs_ar, hs_aw, hs_w, hs_r, hs_b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Expected burst plan and data stream, straight from the sizing rule.
    task automatic build_model(input logic [31:0] s, input logic [31:0] d, input int len);
        int r, b, room;
        exp_ar_addr.delete(); exp_ar_len.delete();
        exp_aw_addr.delete(); exp_aw_len.delete(); exp_wdata.delete();
        for (int i = 0; i < len / 4; i++) exp_wdata.push_back(mem[(s >> 2) + i]);
        r = len;
        while (r > 0) begin
            b = r / 4;
            if (b > 16) b = 16;
            room = (4096 - int'(s % 4096)) / 4;
            if (b > room) b = room;
            room = (4096 - int'(d % 4096)) / 4;
            if (b > room) b = room;
            exp_ar_addr.push_back(s); exp_ar_len.push_back(b);
            exp_aw_addr.push_back(d); exp_aw_len.push_back(b);
            s = s + 32'(b * 4);
            d = d + 32'(b * 4);
            r = r - b * 4;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            hs_ar = s_rst && s_ar && arready;
            hs_aw = s_rst && s_aw && awready;
            hs_w  = s_rst && s_w && wready;
            hs_r  = s_rst && s_rr && rvalid;
            hs_b  = s_rst && s_br && bvalid;
            if (hs_ar) begin
                if (exp_ar_addr.size() == 0) chk("ar_unexpected", 1, 0);
                else begin
                    chk("araddr", s_araddr, exp_ar_addr.pop_front());
                    chk("arlen", s_arlen, 64'(exp_ar_len.pop_front() - 1));
                end
                chk("ar_size_burst_id", s_arattr, {3'd2, 2'd1, 4'd0});
                rd_addr.push_back(s_araddr); rd_len.push_back(int'(s_arlen) + 1);
                r_wait = r_lat; arready = 1'b0;
            end
            if (hs_r) begin
                r_beat++; r_count++;
                if (rlast) begin void'(rd_addr.pop_front()); void'(rd_len.pop_front()); r_beat = 0; end
                rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
            end
            if (hs_aw) begin
                if (exp_aw_addr.size() == 0) chk("aw_unexpected", 1, 0);
                else begin
                    chk("awaddr", s_awaddr, exp_aw_addr.pop_front());
                    chk("awlen", s_awlen, 64'(exp_aw_len.pop_front() - 1));
                end
                chk("aw_size_burst_id", s_awattr, {3'd2, 2'd1, 4'd0});
                wr_addr.push_back(s_awaddr); wr_len.push_back(int'(s_awlen) + 1);
                awready = 1'b0;
            end
            if (hs_w) begin
                if (wr_addr.size() == 0) chk("w_without_aw", 1, 0);
                else begin
                    mem[(wr_addr[0] >> 2) + w_beat] = s_wdata;
                    chk("wlast", s_wlast, (w_beat == wr_len[0] - 1));
                    chk("wstrb", s_wstrb, 4'hF);
                    if (exp_wdata.size() == 0) chk("w_extra_beat", 1, 0);
                    else chk("wdata", s_wdata, exp_wdata.pop_front());
                    w_beat++;
                    if (w_beat == wr_len[0]) begin
                        void'(wr_addr.pop_front()); void'(wr_len.pop_front()); w_beat = 0; b_pend++;
                    end
                end
                wready = 1'b0;
            end
            if (hs_b) begin bvalid = 1'b0; bresp = 2'b00; end

            if (s_rst && s_ar && !hs_ar) chk("ar_hold", {arvalid, araddr, arlen}, {1'b1, s_araddr, s_arlen});
            if (s_rst && s_aw && !hs_aw) chk("aw_hold", {awvalid, awaddr, awlen}, {1'b1, s_awaddr, s_awlen});
            if (s_rst && s_w && !hs_w)   chk("w_hold", {wvalid, wdata, wlast}, {1'b1, s_wdata, s_wlast});
            if (s_rst && wvalid)         chk("w_after_aw", wr_addr.size() > 0, 1);

            if (!rst_n) begin
                arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
                rd_addr.delete(); rd_len.delete(); wr_addr.delete(); wr_len.delete();
                r_beat = 0; w_beat = 0; r_wait = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_pend = 0;
            end else begin
                if (arvalid && !arready) begin
                    if (ar_cnt >= dly) begin arready = 1'b1; ar_cnt = 0; end else ar_cnt++;
                end
                if (awvalid && !awready) begin
                    if (aw_cnt >= dly) begin awready = 1'b1; aw_cnt = 0; end else aw_cnt++;
                end
                if (wvalid && !wready) begin
                    if (w_cnt >= dly) begin wready = 1'b1; w_cnt = 0; end else w_cnt++;
                end
                if (!rvalid && rd_addr.size() > 0) begin
                    if (r_wait > 0) r_wait--;
                    else begin
                        rvalid = 1'b1;
                        rdata  = mem[(rd_addr[0] >> 2) + r_beat];
                        rlast  = (r_beat == rd_len[0] - 1);
                        rresp  = (r_count == rresp_err_beat) ? 2'b10 : 2'b00;
                    end
                end
                if (!bvalid && b_pend > 0) begin
                    bvalid = 1'b1; b_pend--;
                    bresp  = (b_count == bresp_err_burst) ? 2'b10 : 2'b00;
                    b_count++;
                end
            end

            s_rst = rst_n; s_ar = arvalid; s_aw = awvalid; s_w = wvalid; s_rr = rready; s_br = bready;
            s_araddr = araddr; s_arlen = arlen; s_arattr = {arsize, arburst, arid};
            s_awaddr = awaddr; s_awlen = awlen; s_awattr = {awsize, awburst, awid};
            s_wdata = wdata; s_wlast = wlast; s_wstrb = wstrb;
        end
    end

    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int len,
                            input bit exp_err, input bit poke);
        int cyc, nbad;
        r_count = 0; b_count = 0;
        @(posedge clk); #1;
        src_addr = s; dst_addr = d; byte_len = 16'(len); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        if (len > 0) chk("busy_arvalid_after_start", {busy, arvalid, err}, 3'b110);
        else chk("zero_len_done_no_bus", {done, busy, arvalid, awvalid}, 4'b1000);
        if (poke) begin
            @(posedge clk); #1;
            src_addr = 32'h0000_0100; dst_addr = 32'h0000_3F00; byte_len = 16'd8; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
        end
        cyc = 0;
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", done, 1'b1);
        chk("busy_low_at_done", busy, 1'b0);
        chk("err_at_done", err, exp_err);
        @(negedge clk);
        chk("done_one_cycle", {done, arvalid, awvalid}, 3'b000);
        chk("model_drained", exp_ar_addr.size() + exp_aw_addr.size() + exp_wdata.size(), 0);
        nbad = 0;
        for (int i = 0; i < len / 4; i++)
            if (mem[(d >> 2) + i] !== mem[(s >> 2) + i]) nbad++;
        chk("dst_data", nbad, 0);
    endtask

    initial begin
        int cyc;
        logic [31:0] rs, rd;
        int rl;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {busy, done, err, arvalid, awvalid, wvalid, rready, bready, wlast}, 9'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        build_model(32'h0000_0000, 32'h0000_1000, 64);
        chk("model_single", {exp_ar_len.size(), exp_ar_len[0]}, {32'd1, 32'd16});
        run_xfer(32'h0000_0000, 32'h0000_1000, 64, 1'b0, 1'b0);

        build_model(32'h0000_0100, 32'h0000_2100, 200);
        chk("model_tail_count", exp_ar_len.size(), 4);
        chk("model_tail_lens", {8'(exp_ar_len[0]), 8'(exp_ar_len[1]), 8'(exp_ar_len[2]), 8'(exp_ar_len[3])}, 32'h1010_1002);
        chk("model_tail_addr", {exp_ar_addr[3], exp_aw_addr[1]}, {32'h0000_01C0, 32'h0000_2140});
        run_xfer(32'h0000_0100, 32'h0000_2100, 200, 1'b0, 1'b0);

        build_model(32'h0000_0FF0, 32'h0000_2000, 64);
        chk("model_4k_lens", {exp_ar_len[0], exp_ar_len[1]}, {32'd4, 32'd12});
        chk("model_4k_addr", {exp_ar_addr[0], exp_ar_addr[1], exp_aw_addr[1]}, {32'h0FF0, 32'h1000, 32'h2010});
        run_xfer(32'h0000_0FF0, 32'h0000_2000, 64, 1'b0, 1'b0);

        build_model(32'h0000_0040, 32'h0000_2040, 0);
        run_xfer(32'h0000_0040, 32'h0000_2040, 0, 1'b0, 1'b0);

        dly = 5; r_lat = 50;
        build_model(32'h0000_0400, 32'h0000_2800, 128);
        run_xfer(32'h0000_0400, 32'h0000_2800, 128, 1'b0, 1'b1);
        dly = 0; r_lat = 0;

        bresp_err_burst = 0;
        build_model(32'h0000_0200, 32'h0000_3000, 100);
        run_xfer(32'h0000_0200, 32'h0000_3000, 100, 1'b1, 1'b0);
        bresp_err_burst = -1;

        build_model(32'h0000_0600, 32'h0000_3400, 64);
        rresp_err_beat = 0; r_count = 0; b_count = 0;
        @(posedge clk); #1;
        src_addr = 32'h0600; dst_addr = 32'h3400; byte_len = 16'd64; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("err_cleared_on_start", err, 1'b0);
        cyc = 0;
        while (!err && cyc < 200) begin @(negedge clk); cyc++; end
        chk("err_from_rresp", {err, rready}, 2'b11);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_mid_burst", {busy, done, err, arvalid, awvalid, wvalid, rready, bready, wlast}, 9'd0);
        rresp_err_beat = -1;

        for (int t = 0; t < 6; t++) begin
            dly   = $urandom_range(0, 3);
            r_lat = $urandom_range(0, 8);
            rs = $urandom_range(0, 32'h1BFF) & 32'hFFFF_FFFC;
            rd = 32'h2000 + ($urandom_range(0, 32'h1BFF) & 32'hFFFF_FFFC);
            rl = $urandom_range(1, 256) * 4;
            build_model(rs, rd, rl);
            run_xfer(rs, rd, rl, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
